mesi_line_tracker: RTL and testbench
====================================

# mesi_line_tracker

Parametrised MESI coherence state store and transition engine for the last-level cache simulator. It holds a 2-bit MESI state for every line in a SETS x WAYS cache and applies one processor or snooped bus command per accepted request. Each response reports the bus operation to issue, the snoop response to drive, and the before/after states. It adds array-wide clear, illegal-command detection and saturating hit/miss statistics, and sits between the tag/LRU lookup stage (which supplies set and way) and the bus-model logic.

## Interface
- SETS, 16, number of sets (>=2)
- WAYS, 4, ways per set (>=2)
- CNT_W, 16, statistics counter width
- SET_W = $clog2(SETS), WAY_W = $clog2(WAYS): derived widths, not overridable
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_cmd  in  3  0 PR_RD, 1 PR_WR, 2 EVICT, 3 SN_RD, 4 SN_RDX, 5 SN_UPGR, 6 CLEAR_ALL, 7 reserved
- req_set  in  SET_W  set index
- req_way  in  WAY_W  way index
- req_shared  in  1  another cache holds the line (sampled with the request; used only by PR_RD on I)
- rsp_valid  out  1  one-cycle response strobe
- rsp_state_before / rsp_state_after  out  2 each  MESI encoding: M=0, E=1, S=2, I=3
- rsp_bus_op  out  3  0 NONE, 1 READ, 2 RWIM, 3 UPGR, 4 WRITEBACK
- rsp_snoop  out  2  0 NOHIT, 1 HIT, 2 HITM
- rsp_err  out  1  illegal command, illegal transition, or way >= WAYS
- hit_cnt / miss_cnt  out  CNT_W each  processor-request statistics

## Operation
- A request is accepted when req_valid and req_ready are both high. In the acceptance cycle the block reads the addressed entry combinationally, computes the next state, and writes the entry at the clock edge.
- PR_RD:
  - I: bus READ; next state S if req_shared, else E; counts a miss.
  - M/E/S: state unchanged, bus NONE; counts a hit.
- PR_WR:
  - I: bus RWIM, next M; counts a miss.
  - S: bus UPGR, next M; counts a hit.
  - E: next M, bus NONE; counts a hit.
  - M: stays M, bus NONE; counts a hit.
- EVICT: M gives WRITEBACK then I. E/S/I give NONE then I. No counter change.
- SN_RD:
  - M: HITM, WRITEBACK, next S.
  - E/S: HIT, next S.
  - I: NOHIT.
- SN_RDX:
  - M: HITM, WRITEBACK, next I.
  - E/S: HIT, next I.
  - I: NOHIT.
- SN_UPGR:
  - S: HIT, next I.
  - I: NOHIT.
  - E/M: rsp_err=1, state unchanged, bus NONE, snoop NOHIT.
- CLEAR_ALL: set/way are ignored. The block enters the SWEEP state and writes I to every way of one set per cycle, sets 0..SETS-1. Both counters are zeroed on acceptance.
- Reserved command 7 or req_way >= WAYS: rsp_err=1, no array or counter change, bus NONE, snoop NOHIT, state_after = state_before (I when the way is out of range).
- Counters saturate at all-ones and never wrap.
- Snoop commands never change the counters.
- FSM states:
  - IDLE: req_ready=1.
  - SWEEP: req_ready=0. Holds a sweep set counter. Leaves to IDLE after writing set SETS-1.

## Timing
- Reset values: whole array I; FSM IDLE; req_ready=1 on the first cycle after rst deasserts; rsp_valid=0; rsp_state_before/after=I (3); rsp_bus_op=0; rsp_snoop=0; rsp_err=0; counters 0.
- Latency is one cycle: rsp_* are registered and rsp_valid pulses for exactly one cycle, the cycle after acceptance. No backpressure on the response.
- Back-to-back requests are allowed every cycle in IDLE. A request to the same line on the next cycle sees the updated state, because the write lands at the acceptance edge.
- CLEAR_ALL:
  - rsp_valid pulses the cycle after acceptance, with state_before/after reporting the addressed entry and bus NONE.
  - req_ready is low for exactly SETS cycles starting the cycle after acceptance.
  - The first request can be accepted SETS+1 cycles after the CLEAR_ALL edge.
- rst asserted mid-sweep or with a response pending: the sweep is abandoned, rsp_valid=0 next cycle, and the full array is I.
- req_* inputs are ignored while req_ready=0.

## Test plan
- After reset: PR_RD (set 3, way 1, shared=0) then PR_RD on the same line -> first response I->E, READ, miss_cnt=1; second response E->E, NONE, hit_cnt=1.
- PR_RD with shared=1 (I->S, READ), then PR_WR on the same line -> S->M, UPGR; then SN_RD -> M->S, HITM, WRITEBACK; then SN_RDX -> S->I, HIT.
- PR_WR on an I line -> I->M, RWIM. Then SN_UPGR on an E line -> rsp_err=1 with the state left at E. Then req_cmd=7 -> rsp_err=1.
- WAYS=3: request with way=3 -> rsp_err=1, no array change. With CNT_W=2, five PR_RD hits -> hit_cnt stays at 3.
- SETS=16: fill several lines, issue CLEAR_ALL -> req_ready low for exactly 16 cycles, counters 0, then every line reads back I via PR_RD misses.
- Assert rst for one cycle at sweep cycle 5 -> rsp_valid 0 and req_ready 1 the cycle after rst deasserts, and all lines are I.

Source files
------------

// File: rtl/mesi_line_tracker.sv
// MESI coherence state store for a SETS x WAYS cache: applies one processor or
// snooped bus command per accepted request and reports bus/snoop actions.
module mesi_line_tracker #(
  parameter  int SETS  = 16,
  parameter  int WAYS  = 4,
  parameter  int CNT_W = 16,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_cmd_i,
  input  logic [SET_W-1:0] req_set_i,
  input  logic [WAY_W-1:0] req_way_i,
  input  logic             req_shared_i,
  output logic             rsp_valid_o,
  output logic [1:0]       rsp_state_before_o,
  output logic [1:0]       rsp_state_after_o,
  output logic [2:0]       rsp_bus_op_o,
  output logic [1:0]       rsp_snoop_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam logic [1:0] ST_M = 2'd0, ST_E = 2'd1, ST_S = 2'd2, ST_I = 2'd3;
  localparam logic [2:0] CMD_PR_RD = 3'd0, CMD_PR_WR = 3'd1, CMD_EVICT = 3'd2,
                         CMD_SN_RD = 3'd3, CMD_SN_RDX = 3'd4, CMD_SN_UPGR = 3'd5,
                         CMD_CLEAR = 3'd6;
  localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_RWIM = 3'd2,
                         BUS_UPGR = 3'd3, BUS_WB = 3'd4;
  localparam logic [1:0] SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2;

  typedef enum logic {IDLE, SWEEP} fsm_e;

  fsm_e             fsm_q;
  logic             ready_q;
  logic [SET_W-1:0] sweep_q;
  logic [1:0]       mem_q [SETS][WAYS];
  logic             rsp_valid_q, rsp_err_q;
  logic [1:0]       rsp_before_q, rsp_after_q, rsp_snoop_q;
  logic [2:0]       rsp_bus_q;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, hit_cnt_d, miss_cnt_d;

  logic       accept, way_ok, set_ok, line_ok, wr_en, err, is_hit, is_miss;
  logic [1:0] cur_state, state_d, snoop;
  logic [2:0] bus_op;

  always_comb begin
    accept    = req_valid_i && ready_q;
    way_ok    = {1'b0, req_way_i} < (WAY_W+1)'(WAYS);
    set_ok    = {1'b0, req_set_i} < (SET_W+1)'(SETS);
    line_ok   = way_ok && set_ok;
    cur_state = line_ok ? mem_q[req_set_i][req_way_i] : ST_I;
    state_d   = cur_state;
    bus_op    = BUS_NONE;
    snoop     = SNP_NOHIT;
    err       = 1'b0;
    is_hit    = 1'b0;
    is_miss   = 1'b0;
    wr_en     = 1'b0;
    if (req_cmd_i == CMD_CLEAR) begin
      state_d = cur_state;
    end else if (!way_ok || req_cmd_i == 3'd7) begin
      err = 1'b1;
    end else begin
      wr_en = set_ok;
      case (req_cmd_i)
        CMD_PR_RD: begin
          if (cur_state == ST_I) begin
            bus_op  = BUS_READ;
            state_d = req_shared_i ? ST_S : ST_E;
            is_miss = 1'b1;
          end else begin
            is_hit = 1'b1;
          end
        end
        CMD_PR_WR: begin
          state_d = ST_M;
          if (cur_state == ST_I) begin
            bus_op  = BUS_RWIM;
            is_miss = 1'b1;
          end else begin
            bus_op = (cur_state == ST_S) ? BUS_UPGR : BUS_NONE;
            is_hit = 1'b1;
          end
        end
        CMD_EVICT: begin
          bus_op  = (cur_state == ST_M) ? BUS_WB : BUS_NONE;
          state_d = ST_I;
        end
        CMD_SN_RD, CMD_SN_RDX: begin
          if (cur_state == ST_M) begin
            snoop  = SNP_HITM;
            bus_op = BUS_WB;
          end else if (cur_state != ST_I) begin
            snoop = SNP_HIT;
          end
          if (cur_state != ST_I)
            state_d = (req_cmd_i == CMD_SN_RD) ? ST_S : ST_I;
        end
        CMD_SN_UPGR: begin
          // An upgrade snoop against an exclusive copy means the bus is confused.
          if (cur_state == ST_S) begin
            snoop   = SNP_HIT;
            state_d = ST_I;
          end else if (cur_state != ST_I) begin
            err   = 1'b1;
            wr_en = 1'b0;
          end
        end
        default: begin
          err   = 1'b1;
          wr_en = 1'b0;
        end
      endcase
    end
    hit_cnt_d  = (is_hit  && hit_cnt_q  != '1) ? hit_cnt_q  + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = (is_miss && miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q        <= IDLE;
      ready_q      <= 1'b1;
      sweep_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_before_q <= ST_I;
      rsp_after_q  <= ST_I;
      rsp_bus_q    <= BUS_NONE;
      rsp_snoop_q  <= SNP_NOHIT;
      rsp_err_q    <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          mem_q[s][w] <= ST_I;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_before_q <= cur_state;
        rsp_after_q  <= state_d;
        rsp_bus_q    <= bus_op;
        rsp_snoop_q  <= snoop;
        rsp_err_q    <= err;
      end
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            if (req_cmd_i == CMD_CLEAR) begin
              fsm_q      <= SWEEP;
              ready_q    <= 1'b0;
              sweep_q    <= '0;
              hit_cnt_q  <= '0;
              miss_cnt_q <= '0;
            end else begin
              if (wr_en)
                mem_q[req_set_i][req_way_i] <= state_d;
              hit_cnt_q  <= hit_cnt_d;
              miss_cnt_q <= miss_cnt_d;
            end
          end
        end
        SWEEP: begin
          for (int w = 0; w < WAYS; w++)
            mem_q[sweep_q][w] <= ST_I;
          if (sweep_q == SET_W'(SETS-1)) begin
            fsm_q   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + SET_W'(1);
          end
        end
        default: begin
          fsm_q   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o        = ready_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_state_before_o = rsp_before_q;
  assign rsp_state_after_o  = rsp_after_q;
  assign rsp_bus_op_o       = rsp_bus_q;
  assign rsp_snoop_o        = rsp_snoop_q;
  assign rsp_err_o          = rsp_err_q;
  assign hit_cnt_o          = hit_cnt_q;
  assign miss_cnt_o         = miss_cnt_q;

endmodule

// File: tb/tb_mesi_line_tracker.sv
// Directed bench for mesi_line_tracker: expected responses are queued at issue
// time and compared when the one-cycle response strobe appears.
module tb_mesi_line_tracker;
  localparam int SETS = 16, WAYS = 3, CNT_W = 2;
  localparam int SET_W = $clog2(SETS), WAY_W = $clog2(WAYS);
  localparam logic [1:0] M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3;
  localparam logic [2:0] PR_RD = 3'd0, PR_WR = 3'd1, EVICT = 3'd2, SN_RD = 3'd3,
                         SN_RDX = 3'd4, SN_UPGR = 3'd5, CLEAR = 3'd6, RSVD = 3'd7;
  localparam logic [2:0] NONE = 3'd0, READ = 3'd1, RWIM = 3'd2, UPGR = 3'd3, WB = 3'd4;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;

  logic             clk, rst, req_valid, req_ready, req_shared;
  logic [2:0]       req_cmd;
  logic [SET_W-1:0] req_set;
  logic [WAY_W-1:0] req_way;
  logic             rsp_valid, rsp_err;
  logic [1:0]       rsp_before, rsp_after, rsp_snoop;
  logic [2:0]       rsp_bus;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  mesi_line_tracker #(.SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_cmd_i(req_cmd), .req_set_i(req_set), .req_way_i(req_way),
    .req_shared_i(req_shared), .rsp_valid_o(rsp_valid),
    .rsp_state_before_o(rsp_before), .rsp_state_after_o(rsp_after),
    .rsp_bus_op_o(rsp_bus), .rsp_snoop_o(rsp_snoop), .rsp_err_o(rsp_err),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         due;
    logic [1:0] sb, sa, snp;
    logic [2:0] bus;
    logic       err;
    logic [1:0] hc, mc;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0, miscompares = 0, cyc = 0;
  int   mhit = 0, mmiss = 0;

  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: a strobe is required exactly on the due cycle, and nowhere else.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        check({e.tag, "_valid"},  32'(rsp_valid),  32'd1);
        check({e.tag, "_before"}, 32'(rsp_before), 32'(e.sb));
        check({e.tag, "_after"},  32'(rsp_after),  32'(e.sa));
        check({e.tag, "_bus"},    32'(rsp_bus),    32'(e.bus));
        check({e.tag, "_snoop"},  32'(rsp_snoop),  32'(e.snp));
        check({e.tag, "_err"},    32'(rsp_err),    32'(e.err));
        check({e.tag, "_hits"},   32'(hit_cnt),    32'(e.hc));
        check({e.tag, "_misses"}, 32'(miss_cnt),   32'(e.mc));
      end else begin
        check("rsp_valid_quiet", 32'(rsp_valid), 32'd0);
      end
    end
  end

  // Called at a negedge; drives one request and queues its expected response.
  task automatic issue(string tag, logic [2:0] cmd, int set, int way, logic sh,
                       logic [1:0] sb, logic [1:0] sa, logic [2:0] bus,
                       logic [1:0] snp, logic err);
    exp_t e;
    int   n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_cmd    = cmd;
    req_set    = set[SET_W-1:0];
    req_way    = way[WAY_W-1:0];
    req_shared = sh;
    if (cmd == CLEAR) begin
      mhit  = 0;
      mmiss = 0;
    end else if (!err && cmd <= PR_WR) begin
      if (sb == I) mmiss = (mmiss < 3) ? mmiss + 1 : 3;
      else         mhit  = (mhit  < 3) ? mhit  + 1 : 3;
    end
    e.tag = tag; e.due = cyc + 1;
    e.sb = sb; e.sa = sa; e.bus = bus; e.snp = snp; e.err = err;
    e.hc = 2'(mhit); e.mc = 2'(mmiss);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_set = '0; req_way = '0;
    req_shared = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready",  32'(req_ready),  32'd1);
    check("reset_before", 32'(rsp_before), 32'(I));
    check("reset_after",  32'(rsp_after),  32'(I));
    check("reset_bus",    32'(rsp_bus),    32'(NONE));
    check("reset_snoop",  32'(rsp_snoop),  32'(NOHIT));
    check("reset_err",    32'(rsp_err),    32'd0);
    check("reset_hits",   32'(hit_cnt),    32'd0);
    check("reset_misses", 32'(miss_cnt),   32'd0);

    issue("rd_miss",    PR_RD,  3, 1, 0, I, E, READ, NOHIT, 0);
    issue("rd_hit",     PR_RD,  3, 1, 0, E, E, NONE, NOHIT, 0);
    issue("rd_shared",  PR_RD,  5, 0, 1, I, S, READ, NOHIT, 0);
    issue("wr_upgr",    PR_WR,  5, 0, 0, S, M, UPGR, NOHIT, 0);
    issue("snrd_m",     SN_RD,  5, 0, 0, M, S, WB,   HITM,  0);
    issue("snrdx_s",    SN_RDX, 5, 0, 0, S, I, NONE, HIT,   0);
    idle(1);
    issue("wr_miss",    PR_WR,  6, 2, 0, I, M, RWIM, NOHIT, 0);
    issue("snupgr_e",   SN_UPGR,3, 1, 0, E, E, NONE, NOHIT, 1);
    issue("rd_still_e", PR_RD,  3, 1, 0, E, E, NONE, NOHIT, 0);
    issue("rsvd_cmd",   RSVD,   3, 1, 0, E, E, NONE, NOHIT, 1);
    issue("snupgr_i",   SN_UPGR,5, 0, 0, I, I, NONE, NOHIT, 0);
    issue("way_oor",    PR_WR,  2, 3, 0, I, I, NONE, NOHIT, 1);
    for (int k = 0; k < 5; k++)
      issue($sformatf("sat_hit%0d", k), PR_RD, 3, 1, 0, E, E, NONE, NOHIT, 0);
    issue("evict_m",    EVICT,  6, 2, 0, M, I, WB,   NOHIT, 0);
    issue("evict_e",    EVICT,  3, 1, 0, E, I, NONE, NOHIT, 0);
    issue("evict_i",    EVICT,  3, 1, 0, I, I, NONE, NOHIT, 0);
    issue("fill0",      PR_WR,  0, 0, 0, I, M, RWIM, NOHIT, 0);
    issue("fill1",      PR_RD, 15, 2, 0, I, E, READ, NOHIT, 0);
    issue("fill2",      PR_RD,  8, 1, 1, I, S, READ, NOHIT, 0);
    issue("clear",      CLEAR, 15, 2, 0, E, E, NONE, NOHIT, 0);
    req_valid = 1'b0;
    n = 0;
    while (req_ready === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("clear_busy_cycles", 32'(n), 32'(SETS));
    check("clear_ready_back", 32'(req_ready), 32'd1);
    issue("post_clr0",  PR_RD,  0, 0, 0, I, E, READ, NOHIT, 0);
    issue("post_clr1",  PR_RD, 15, 2, 0, I, E, READ, NOHIT, 0);
    issue("post_clr2",  PR_RD,  8, 1, 0, I, E, READ, NOHIT, 0);
    issue("post_clr3",  PR_RD, 15, 0, 1, I, S, READ, NOHIT, 0);
    issue("fill3",      PR_WR, 10, 1, 0, I, M, RWIM, NOHIT, 0);
    issue("fill4",      PR_WR,  1, 0, 0, I, M, RWIM, NOHIT, 0);
    issue("clear2",     CLEAR,  0, 0, 0, E, E, NONE, NOHIT, 0);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mhit = 0;
    mmiss = 0;
    @(negedge clk);
    check("rst_sweep_valid",  32'(rsp_valid),  32'd0);
    check("rst_sweep_ready",  32'(req_ready),  32'd1);
    check("rst_sweep_before", 32'(rsp_before), 32'(I));
    check("rst_sweep_hits",   32'(hit_cnt),    32'd0);
    check("rst_sweep_misses", 32'(miss_cnt),   32'd0);
    issue("post_rst0",  PR_RD, 10, 1, 0, I, E, READ, NOHIT, 0);
    issue("post_rst1",  PR_RD,  1, 0, 0, I, E, READ, NOHIT, 0);
    issue("post_rst2",  PR_RD,  0, 0, 0, I, E, READ, NOHIT, 0);
    issue("snrd_e",     SN_RD,  1, 0, 0, E, S, NONE, HIT,   0);
    issue("snrd_i",     SN_RD,  4, 0, 0, I, I, NONE, NOHIT, 0);
    issue("snrdx_e",    SN_RDX,10, 1, 0, E, I, NONE, HIT,   0);
    issue("wr_upgr2",   PR_WR,  1, 0, 0, S, M, UPGR, NOHIT, 0);
    issue("snrdx_m",    SN_RDX, 1, 0, 0, M, I, WB,   HITM,  0);
    idle(3);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
